flight_mode_controller: RTL and testbench
=========================================

// Module: flight_mode_controller
// PURPOSE
//   Sequences the spatial position datapath (x/y/z axis position registers fed by
//   the mode and position one-hot muxes). Owns the mode/position select lines.
//   Time-shares one axis-update slot across x,y,z per tick and runs the warp
//   charge -> warp -> cooldown sequence. Sits between command input and the axes.
// PARAMETERS
//   CHARGE_CYCLES    8   clocks spent in CHARGE before WARP
//   WARP_SWEEPS      4   completed x/y/z sweeps spent in WARP
//   COOLDOWN_CYCLES  16  clocks in COOL before warp may be requested again
//   CNT_W            5   counter width; must hold max(all three params)
// PORTS
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   mode_req     in   4  one-hot: 0001 reset, 0010 attack, 0100 defense, 1000 stealth
//   mode_valid   in   1  mode_req valid
//   mode_ready   out  1  mode_req accepted on mode_valid & mode_ready
//   warp_req     in   1  single-cycle warp request
//   tick         in   1  axis-update strobe, one cycle wide
//   mode_sel     out  4  one-hot select to the mode (velocity) mux
//   pos_sel      out  4  one-hot: 0001 reset, 0010 normal, 0100 warp; 1000 never driven
//   axis_sel     out  3  one-hot axis being written: [0] x, [1] y, [2] z
//   axis_we      out  1  write strobe to the axis register selected by axis_sel
//   warp_active  out  1  high in WARP
//   err          out  1  sticky: non-one-hot mode_req accepted
//   overrun      out  1  sticky: tick arrived during an in-progress sweep
// BEHAVIOUR
//   Reset (async): state=RST_POS, mode_sel=0001, pos_sel=0001, axis_sel=000,
//     axis_we=0, warp_active=0, mode_ready=0, err=0, overrun=0, counters=0.
//   States: RST_POS, NORMAL, CHARGE, WARP, COOL. All outputs registered.
//   Sweep: 3 consecutive cycles, axis_sel 001,010,100 with axis_we=1; starts the
//     cycle after tick (RST_POS starts sweep without tick). A tick during a sweep
//     is dropped and sets overrun.
//   RST_POS: pos_sel=0001; one sweep, then -> NORMAL, mode_sel=0001 kept.
//   NORMAL: pos_sel=0010. warp_req with mode_sel!=0001 -> CHARGE; else ignored.
//   CHARGE: pos_sel=0010; count CHARGE_CYCLES clocks -> WARP. Ticks sweep as normal.
//   WARP: pos_sel=0100, warp_active=1; after WARP_SWEEPS completed sweeps -> COOL
//     (transition at end of last sweep cycle).
//   COOL: pos_sel=0010; COOLDOWN_CYCLES clocks -> NORMAL. warp_req ignored.
//   mode_ready=1 only in NORMAL or COOL and no sweep in progress (sweep start has
//     priority over acceptance in the same cycle: ready drops that cycle).
//   Accepted legal mode: mode_sel updates next cycle; 0001 also -> RST_POS.
//   Accepted non-one-hot mode: mode_sel unchanged, err set.
//   warp_req and mode accept same cycle in NORMAL: mode applied, warp_req
//     evaluated against the new mode (0001 request wins: -> RST_POS, warp dropped).
//   Counters wrap never: they stop at terminal count and clear on state exit.
//   rst_n low mid-sweep/mid-warp: immediate return to reset values.
// CONFIGURATION
//   WARP_ABORT_EN defined: in CHARGE/WARP mode_ready=1 when no sweep in progress;
//     only mode_req=0001 is acted on (-> RST_POS, warp_active=0 next cycle, counters
//     cleared); other accepted requests are discarded (err not set).
//   WARP_ABORT_EN undefined: mode_ready=0 throughout CHARGE/WARP; no abort path.
// TESTING
//   Release rst_n -> axis_sel 001,010,100 with axis_we=1, pos_sel=0001, then NORMAL.
//   mode_req=0010 valid in NORMAL -> mode_sel=0010 next cycle; tick -> 3-cycle
//     sweep with pos_sel=0010; second tick mid-sweep -> overrun=1, no extra sweep.
//   mode 0100, warp_req -> CHARGE 8 clks, WARP with pos_sel=0100 for 4 ticks'
//     sweeps, COOL 16 clks, back to NORMAL; warp_req in COOL ignored.
//   mode_req=0110 accepted -> err=1, mode_sel unchanged; warp_req with
//     mode_sel=0001 -> stays NORMAL.
//   WARP_ABORT_EN: mode_req=0001 during WARP -> RST_POS sweep, warp_active=0;
//     without macro mode_ready stays 0 until COOL.
//   rst_n pulsed low mid-WARP -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/flight_mode_if.sv
// Command/select bundle between the flight-mode sequencer and the axis datapath.
// master = command source / datapath side, slave = flight_mode_controller.
interface flight_mode_if;
    logic [3:0] mode_req;
    logic       mode_valid;
    logic       mode_ready;
    logic       warp_req;
    logic       tick;
    logic [3:0] mode_sel;
    logic [3:0] pos_sel;
    logic [2:0] axis_sel;
    logic       axis_we;
    logic       warp_active;
    logic       err;
    logic       overrun;

    modport master (
        output mode_req, mode_valid, warp_req, tick,
        input  mode_ready, mode_sel, pos_sel, axis_sel, axis_we,
               warp_active, err, overrun
    );

    modport slave (
        input  mode_req, mode_valid, warp_req, tick,
        output mode_ready, mode_sel, pos_sel, axis_sel, axis_we,
               warp_active, err, overrun
    );
endinterface

// File: rtl/flight_mode_controller.sv
// Sequences the x/y/z position datapath: mode/position selects, time-shared axis
// sweeps and the charge->warp->cooldown run. Optional feature macro: WARP_ABORT_EN.
module flight_mode_controller #(
    parameter int CHARGE_CYCLES   = 8,
    parameter int WARP_SWEEPS     = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    flight_mode_if.slave bus_if
);

    typedef enum logic [2:0] {
        ST_RST_POS,
        ST_NORMAL,
        ST_CHARGE,
        ST_WARP,
        ST_COOL
    } state_e;

    localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(WARP_SWEEPS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]       MODE_RESET  = 4'b0001;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mode_sel_q, mode_sel_d;
    logic [3:0]       pos_sel_q, pos_sel_d;
    logic [2:0]       axis_sel_q, axis_sel_d;
    logic             axis_we_q, axis_we_d;
    logic             warp_active_q, warp_active_d;
    logic             mode_ready_q, mode_ready_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;

    logic       accept, legal, sweep_start, sweep_done, abort;
    logic [3:0] eff_mode;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST_POS;
            cnt_q         <= '0;
            mode_sel_q    <= MODE_RESET;
            pos_sel_q     <= 4'b0001;
            axis_sel_q    <= 3'b000;
            axis_we_q     <= 1'b0;
            warp_active_q <= 1'b0;
            mode_ready_q  <= 1'b0;
            err_q         <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_sel_q    <= mode_sel_d;
            pos_sel_q     <= pos_sel_d;
            axis_sel_q    <= axis_sel_d;
            axis_we_q     <= axis_we_d;
            warp_active_q <= warp_active_d;
            mode_ready_q  <= mode_ready_d;
            err_q         <= err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign accept      = bus_if.mode_valid && mode_ready_q;
    assign legal       = $onehot(bus_if.mode_req);
    assign eff_mode    = (accept && legal) ? bus_if.mode_req : mode_sel_q;
    // A sweep is in progress exactly while axis_we_q is high; RST_POS self-starts one.
    assign sweep_start = !axis_we_q && (bus_if.tick || (state_q == ST_RST_POS));
    assign sweep_done  = axis_we_q && axis_sel_q[2];

`ifdef WARP_ABORT_EN
    assign abort = accept && (bus_if.mode_req == MODE_RESET);
`else
    assign abort = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_sel_d = mode_sel_q;
        err_d      = err_q;
        overrun_d  = overrun_q || (bus_if.tick && axis_we_q);
        axis_sel_d = 3'b000;
        axis_we_d  = 1'b0;

        if (axis_we_q) begin
            // 001 -> 010 -> 100 -> 000 falls out of a plain left shift.
            axis_sel_d = axis_sel_q << 1;
            axis_we_d  = !axis_sel_q[2];
        end else if (sweep_start) begin
            axis_sel_d = 3'b001;
            axis_we_d  = 1'b1;
        end

        unique case (state_q)
            ST_RST_POS: begin
                if (sweep_done) state_d = ST_NORMAL;
            end
            ST_NORMAL, ST_COOL: begin
                if (accept && legal) mode_sel_d = bus_if.mode_req;
                if (accept && !legal) err_d = 1'b1;
                if (accept && legal && (bus_if.mode_req == MODE_RESET)) begin
                    state_d = ST_RST_POS;
                end else if (state_q == ST_NORMAL) begin
                    if (bus_if.warp_req && (eff_mode != MODE_RESET)) state_d = ST_CHARGE;
                end else if (cnt_q == COOL_LAST) begin
                    state_d = ST_NORMAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHARGE: begin
                if (abort) begin
                    state_d    = ST_RST_POS;
                    mode_sel_d = MODE_RESET;
                end else if (cnt_q == CHARGE_LAST) begin
                    state_d = ST_WARP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WARP: begin
                if (abort) begin
                    state_d    = ST_RST_POS;
                    mode_sel_d = MODE_RESET;
                end else if (sweep_done) begin
                    if (cnt_q == SWEEP_LAST) state_d = ST_COOL;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RST_POS;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        pos_sel_d     = 4'b0010;
        warp_active_d = 1'b0;
        mode_ready_d  = 1'b0;
        unique case (state_d)
            ST_RST_POS: pos_sel_d = 4'b0001;
            ST_WARP: begin
                pos_sel_d     = 4'b0100;
                warp_active_d = 1'b1;
            end
            default: pos_sel_d = 4'b0010;
        endcase
        if (!axis_we_d) begin
            mode_ready_d = (state_d == ST_NORMAL) || (state_d == ST_COOL);
`ifdef WARP_ABORT_EN
            if ((state_d == ST_CHARGE) || (state_d == ST_WARP)) mode_ready_d = 1'b1;
`endif
        end
    end

    assign bus_if.mode_ready  = mode_ready_q;
    assign bus_if.mode_sel    = mode_sel_q;
    assign bus_if.pos_sel     = pos_sel_q;
    assign bus_if.axis_sel    = axis_sel_q;
    assign bus_if.axis_we     = axis_we_q;
    assign bus_if.warp_active = warp_active_q;
    assign bus_if.err         = err_q;
    assign bus_if.overrun     = overrun_q;

endmodule

// File: tb/tb_flight_mode_controller.sv
// Directed vector table plus hand-written sequences for flight_mode_controller.
module tb_flight_mode_controller;

`ifdef WARP_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    flight_mode_if bus();

    flight_mode_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mode_req;
        logic        valid;
        logic        warp;
        logic        tick;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [15:0] ex(input logic [2:0] axis, input logic we,
                                       input logic [3:0] pos, input logic [3:0] msel,
                                       input logic rdy, input logic wa,
                                       input logic er, input logic ov);
        return {axis, we, pos, msel, rdy, wa, er, ov};
    endfunction

    function automatic logic [15:0] outs();
        return {bus.axis_sel, bus.axis_we, bus.pos_sel, bus.mode_sel,
                bus.mode_ready, bus.warp_active, bus.err, bus.overrun};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic v, input logic w, input logic t);
        bus.mode_req   = m;
        bus.mode_valid = v;
        bus.warp_req   = w;
        bus.tick       = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Fields: axis, we, pos, mode_sel, ready, warp_active, err, overrun
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b001, 1, 4'b0001, 4'b0001, 0, 0, 0, 0)};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b010, 1, 4'b0001, 4'b0001, 0, 0, 0, 0)};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b100, 1, 4'b0001, 4'b0001, 0, 0, 0, 0)};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0001, 1, 0, 0, 0)};
        tbl[4]  = '{4'b0010, 1'b1, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0010, 1, 0, 0, 0)};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b1, ex(3'b001, 1, 4'b0010, 4'b0010, 0, 0, 0, 0)};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, ex(3'b010, 1, 4'b0010, 4'b0010, 0, 0, 0, 1)};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b100, 1, 4'b0010, 4'b0010, 0, 0, 0, 1)};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0010, 1, 0, 0, 1)};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0010, 1, 0, 0, 1)};
        tbl[10] = '{4'b0110, 1'b1, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0010, 1, 0, 1, 1)};
        tbl[11] = '{4'b0001, 1'b1, 1'b1, 1'b0, ex(3'b000, 0, 4'b0001, 4'b0001, 0, 0, 1, 1)};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b001, 1, 4'b0001, 4'b0001, 0, 0, 1, 1)};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b010, 1, 4'b0001, 4'b0001, 0, 0, 1, 1)};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b100, 1, 4'b0001, 4'b0001, 0, 0, 1, 1)};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0001, 1, 0, 1, 1)};
        tbl[16] = '{4'b0000, 1'b0, 1'b1, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0001, 1, 0, 1, 1)};
        tbl[17] = '{4'b0100, 1'b1, 1'b1, 1'b0, ex(3'b000, 0, 4'b0010, 4'b0100, ABORT, 0, 1, 1)};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'(ex(3'b000, 0, 4'b0001, 4'b0001, 0, 0, 0, 0)));
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].mode_req, tbl[i].valid, tbl[i].warp, tbl[i].tick);
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // CHARGE lasts exactly 8 clocks (first one already elapsed above).
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("charge_hold%0d", k), 32'({bus.pos_sel, bus.warp_active, bus.mode_ready}),
                  32'({4'b0010, 1'b0, ABORT}));
        end
        step();
        check("warp_entry", 32'({bus.pos_sel, bus.warp_active}), 32'({4'b0100, 1'b1}));

        // Four tick-driven sweeps in WARP; the last one ends the warp.
        for (int s = 0; s < 4; s++) begin
            drive(4'b0000, 1'b0, 1'b0, 1'b1);
            step();
            drive(4'b0000, 1'b0, 1'b0, 1'b0);
            check($sformatf("warp_sweep%0d_start", s), 32'({bus.axis_sel, bus.axis_we, bus.pos_sel}),
                  32'({3'b001, 1'b1, 4'b0100}));
            step();
            step();
            step();
            check($sformatf("warp_sweep%0d_end", s),
                  32'({bus.axis_sel, bus.axis_we, bus.pos_sel, bus.warp_active, bus.mode_ready}),
                  (s < 3) ? 32'({3'b000, 1'b0, 4'b0100, 1'b1, ABORT})
                          : 32'({3'b000, 1'b0, 4'b0010, 1'b0, 1'b1}));
        end

        // COOL: warp_req held for all 16 cooldown clocks is ignored, then accepted.
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("cool_ignore_warp%0d", k), 32'({bus.pos_sel, bus.mode_ready, bus.warp_active}),
                  32'({4'b0010, 1'b1, 1'b0}));
        end
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        check("normal_warp_after_cool", 32'({bus.mode_ready, bus.warp_active}), 32'({ABORT, 1'b0}));

        // Async reset in the middle of a WARP sweep.
        repeat (8) step();
        check("warp_again", 32'(bus.warp_active), 32'(1'b1));
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        check("mid_warp_sweep", 32'({bus.axis_sel, bus.axis_we}), 32'({3'b001, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mid_warp", 32'(outs()), 32'(ex(3'b000, 0, 4'b0001, 4'b0001, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("reset_resweep_normal", 32'(outs()), 32'(ex(3'b000, 0, 4'b0010, 4'b0001, 1, 0, 0, 0)));

        // Mode requests while in WARP: acted on only with the abort feature.
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (8) step();
        check("warp_ready", 32'({bus.warp_active, bus.mode_ready}), 32'({1'b1, ABORT}));
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        check("warp_nonreset_discard", 32'({bus.mode_sel, bus.err, bus.warp_active}),
              32'({4'b0100, 1'b0, 1'b1}));
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        check("warp_abort", 32'({bus.warp_active, bus.pos_sel, bus.mode_sel}),
              ABORT ? 32'({1'b0, 4'b0001, 4'b0001}) : 32'({1'b1, 4'b0100, 4'b0100}));
        step();
        check("abort_sweep", 32'({bus.axis_sel, bus.axis_we}),
              ABORT ? 32'({3'b001, 1'b1}) : 32'({3'b000, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
